// File: rtl/demux1to2_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input stream steered by s into
// two independent DEPTH-entry FIFOs, so a stalled consumer never blocks the other side.
module demux1to2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [CW-1:0]    a_count,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CW-1:0]    b_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_a, rd_a, wr_b, rd_b;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic             full_a, full_b;
  logic             push_a, push_b, pop_a, pop_b;

  assign full_a = (cnt_a == CW'(DEPTH));
  assign full_b = (cnt_b == CW'(DEPTH));

  // Readiness looks only at the selected FIFO's fill level, never at the consumer.
  assign in_ready = ~flush & (s ? ~full_b : ~full_a);

  assign push_a = in_valid & in_ready & ~s;
  assign push_b = in_valid & in_ready & s;

  assign a_valid = (cnt_a != '0);
  assign b_valid = (cnt_b != '0);
  assign pop_a   = a_valid & a_ready;
  assign pop_b   = b_valid & b_ready;

  assign a_data  = a_valid ? mem_a[rd_a] : '0;
  assign b_data  = b_valid ? mem_b[rd_b] : '0;
  assign a_count = cnt_a;
  assign b_count = cnt_b;

  always_ff @(posedge clk) begin
    if (push_a) mem_a[wr_a] <= in_data;
    if (push_b) mem_b[wr_b] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_a  <= '0;
      rd_a  <= '0;
      cnt_a <= '0;
    end else if (flush) begin
      wr_a  <= '0;
      rd_a  <= '0;
      cnt_a <= '0;
    end else begin
      if (push_a) wr_a <= wr_a + 1'b1;
      if (pop_a)  rd_a <= rd_a + 1'b1;
      case ({push_a, pop_a})
        2'b10:   cnt_a <= cnt_a + 1'b1;
        2'b01:   cnt_a <= cnt_a - 1'b1;
        default: cnt_a <= cnt_a;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_b  <= '0;
      rd_b  <= '0;
      cnt_b <= '0;
    end else if (flush) begin
      wr_b  <= '0;
      rd_b  <= '0;
      cnt_b <= '0;
    end else begin
      if (push_b) wr_b <= wr_b + 1'b1;
      if (pop_b)  rd_b <= rd_b + 1'b1;
      case ({push_b, pop_b})
        2'b10:   cnt_b <= cnt_b + 1'b1;
        2'b01:   cnt_b <= cnt_b - 1'b1;
        default: cnt_b <= cnt_b;
      endcase
    end
  end

endmodule

// File: tb/tb_demux1to2_buf.sv
// Directed bench for demux1to2_buf: vector table for routing, backpressure and flush,
// plus hand-written sequences for wrap-around and asynchronous reset.
module tb_demux1to2_buf;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, s;
  logic [31:0] in_data, a_data, b_data;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [1:0]  a_count, b_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        iv, s, fl, ar, br;
    logic [31:0] d;
    logic        ir;
    logic        av;
    logic [31:0] ad;
    logic [1:0]  ac;
    logic        bv;
    logic [31:0] bd;
    logic [1:0]  bc;
  } vec_t;

  vec_t vecs[$];

  demux1to2_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .s(s),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_count(a_count),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic sel, input logic fl,
                       input logic ar, input logic br, input logic [31:0] d);
    in_valid = iv;
    s        = sel;
    flush    = fl;
    a_ready  = ar;
    b_ready  = br;
    in_data  = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    resetn = 1'b0;

    // {iv, s, flush, a_ready, b_ready, data, exp in_ready, exp a: valid,data,count, exp b: valid,data,count}
    vecs.push_back('{1,0,0,1,1,32'h11, 1, 1,32'h11,2'd1, 0,32'h0,2'd0});
    vecs.push_back('{1,1,0,1,1,32'h22, 1, 0,32'h0,2'd0,  1,32'h22,2'd1});
    vecs.push_back('{0,0,0,1,1,32'h0,  1, 0,32'h0,2'd0,  0,32'h0,2'd0});
    vecs.push_back('{1,0,0,0,0,32'hA0, 1, 1,32'hA0,2'd1, 0,32'h0,2'd0});
    vecs.push_back('{1,0,0,0,0,32'hA1, 1, 1,32'hA0,2'd2, 0,32'h0,2'd0});
    vecs.push_back('{1,0,0,0,0,32'hA2, 0, 1,32'hA0,2'd2, 0,32'h0,2'd0});
    vecs.push_back('{1,1,0,0,0,32'hB0, 1, 1,32'hA0,2'd2, 1,32'hB0,2'd1});
    vecs.push_back('{1,0,0,1,0,32'hA2, 0, 1,32'hA1,2'd1, 1,32'hB0,2'd1});
    vecs.push_back('{1,0,0,1,1,32'hA2, 1, 1,32'hA2,2'd1, 0,32'h0,2'd0});
    vecs.push_back('{0,0,0,1,1,32'h0,  1, 0,32'h0,2'd0,  0,32'h0,2'd0});
    vecs.push_back('{1,0,0,0,0,32'hC0, 1, 1,32'hC0,2'd1, 0,32'h0,2'd0});
    vecs.push_back('{1,0,0,0,0,32'hC1, 1, 1,32'hC0,2'd2, 0,32'h0,2'd0});
    vecs.push_back('{1,1,0,0,0,32'hD0, 1, 1,32'hC0,2'd2, 1,32'hD0,2'd1});
    vecs.push_back('{1,1,1,1,1,32'hEE, 0, 0,32'h0,2'd0,  0,32'h0,2'd0});
    vecs.push_back('{0,0,0,0,0,32'h0,  1, 0,32'h0,2'd0,  0,32'h0,2'd0});

    repeat (3) @(negedge clk);
    chk("rst a_valid", {31'b0, a_valid}, 32'd0);
    chk("rst a_count", {30'b0, a_count}, 32'd0);
    resetn = 1'b1;
    #1;
    chk("idle in_ready", {31'b0, in_ready}, 32'd1);
    chk("idle a_valid",  {31'b0, a_valid},  32'd0);
    chk("idle b_valid",  {31'b0, b_valid},  32'd0);
    chk("idle a_data",   a_data,            32'd0);
    chk("idle b_data",   b_data,            32'd0);
    chk("idle a_count",  {30'b0, a_count},  32'd0);
    chk("idle b_count",  {30'b0, b_count},  32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].s, vecs[i].fl, vecs[i].ar, vecs[i].br, vecs[i].d);
      #1;
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].ir});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d a_valid", i), {31'b0, a_valid}, {31'b0, vecs[i].av});
      chk($sformatf("v%0d a_data", i),  a_data,            vecs[i].ad);
      chk($sformatf("v%0d a_count", i), {30'b0, a_count}, {30'b0, vecs[i].ac});
      chk($sformatf("v%0d b_valid", i), {31'b0, b_valid}, {31'b0, vecs[i].bv});
      chk($sformatf("v%0d b_data", i),  b_data,            vecs[i].bd);
      chk($sformatf("v%0d b_count", i), {30'b0, b_count}, {30'b0, vecs[i].bc});
    end

    // Eight back-to-back beats to a, drained every cycle: count holds at 1, pointers wrap.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'(i));
      #1;
      chk($sformatf("wrap%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d a_valid", i), {31'b0, a_valid}, 32'd1);
      chk($sformatf("wrap%0d a_data", i),  a_data,            32'(i));
      chk($sformatf("wrap%0d a_count", i), {30'b0, a_count}, 32'd1);
      chk($sformatf("wrap%0d b_valid", i), {31'b0, b_valid}, 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    chk("wrap drain a_count", {30'b0, a_count}, 32'd0);

    // Fill a, then drop reset between edges: outputs clear with no clock edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("pre-rst a_count", {30'b0, a_count}, 32'd2);
    chk("pre-rst a_data",  a_data,            32'hF0);
    #1;
    resetn = 1'b0;
    #1;
    chk("async a_valid", {31'b0, a_valid}, 32'd0);
    chk("async a_count", {30'b0, a_count}, 32'd0);
    chk("async a_data",  a_data,            32'd0);
    chk("async in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst a_valid", {31'b0, a_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
